i2c_master_byte_ctrl: RTL and testbench

Byte-level controller of the I2C master, directly upstream of `i2c_master_bit_ctrl`. It accepts one byte command from the host register layer: START, WRITE, READ and STOP, in any legal combination. It breaks that command into the bit controller's one-hot bit commands and shifts 8 data bits through the bit controller. It also handles the 9th ACK bit and reports completion with a single-cycle `cmd_ack`.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_byte_shreg.sv | 35 +++
 rtl/i2c_master_byte_ctrl.sv | 170 +++++++++++++++++
 tb/tb_i2c_master_byte_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master byte controller: bit-controller
// command encodings and the byte-level state enumeration.
package i2c_pkg;

    // One-hot bit commands understood by i2c_master_bit_ctrl
    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

endpackage

// File: rtl/i2c_byte_shreg.sv
// Byte shift register and bit counter for the I2C byte controller.
// Load takes the host byte and arms an 8-bit count; shift moves the
// received bit in at the LSB while the MSB is presented for transmit.
module i2c_byte_shreg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    input  logic       rxd,
    output logic [7:0] sr,
    output logic       cnt_done
);

    logic [2:0] cnt;

    // Shift register and down-counter; load wins over shift
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= 8'h00;
            cnt <= 3'd0;
        end else if (load) begin
            sr  <= din;
            cnt <= 3'd7;
        end else if (shift) begin
            sr  <= {sr[6:0], rxd};
            cnt <= cnt - 3'd1;
        end
    end

    assign cnt_done = (cnt == 3'd0);

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller. Splits a host START/WRITE/READ/STOP command
// into one-hot bit commands for i2c_master_bit_ctrl, shifts 8 data bits,
// handles the ACK bit and pulses cmd_ack once the command completes.
// Optional build macro: I2C_AUTO_STOP_ON_NACK_EN -- when defined, a NACK
// received after a WRITE forces a STOP before cmd_ack.
module i2c_master_byte_ctrl
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_al,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       core_al
);

    state_t state;
    logic   go;
    logic   load;
    logic   shift;
    logic   cnt_done;
    logic   ack_stop;
    logic [7:0] sr;

    // A new command is blocked in the cmd_ack cycle of the previous one
    assign go     = (read | write | stop) & ~cmd_ack;
    assign i2c_al = core_al;
    assign dout   = sr;

    // During the ACK bit the bit controller transmits the host's ACK level
    assign core_txd = (state == ST_ACK) ? ack_in : sr[7];

`ifdef I2C_AUTO_STOP_ON_NACK_EN
    // A slave NACK after a write terminates the transfer with STOP
    assign ack_stop = stop | (write & ~read & core_rxd);
`else
    assign ack_stop = stop;
`endif

    i2c_byte_shreg u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .din      (din),
        .rxd      (core_rxd),
        .sr       (sr),
        .cnt_done (cnt_done)
    );

    // Shift-register control decoded from the current state; frozen on arbitration loss
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        if (!core_al) begin
            case (state)
                ST_IDLE:           load  = go;
                ST_START:          load  = core_ack;
                ST_WRITE, ST_READ: shift = core_ack;
                default:           ;
            endcase
        end
    end

    // Byte sequencer with registered bit command, cmd_ack and ack_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            core_cmd <= CMD_NOP;
            cmd_ack  <= 1'b0;
            ack_out  <= 1'b0;
        end else if (core_al) begin
            // Abort silently: no cmd_ack is ever produced for a lost command
            state    <= ST_IDLE;
            core_cmd <= CMD_NOP;
            cmd_ack  <= 1'b0;
        end else begin
            cmd_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        if (start) begin
                            state    <= ST_START;
                            core_cmd <= CMD_START;
                        end else if (read) begin
                            state    <= ST_READ;
                            core_cmd <= CMD_READ;
                        end else if (write) begin
                            state    <= ST_WRITE;
                            core_cmd <= CMD_WRITE;
                        end else begin
                            state    <= ST_STOP;
                            core_cmd <= CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (core_ack) begin
                        if (read) begin
                            state    <= ST_READ;
                            core_cmd <= CMD_READ;
                        end else begin
                            state    <= ST_WRITE;
                            core_cmd <= CMD_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (core_ack) begin
                        if (cnt_done) begin
                            // Ninth bit: sample the slave's ACK
                            state    <= ST_ACK;
                            core_cmd <= CMD_READ;
                        end else begin
                            core_cmd <= CMD_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (core_ack) begin
                        if (cnt_done) begin
                            // Ninth bit: drive ack_in to the slave
                            state    <= ST_ACK;
                            core_cmd <= CMD_WRITE;
                        end else begin
                            core_cmd <= CMD_READ;
                        end
                    end
                end
                ST_ACK: begin
                    if (core_ack) begin
                        ack_out <= core_rxd;
                        if (ack_stop) begin
                            state    <= ST_STOP;
                            core_cmd <= CMD_STOP;
                        end else begin
                            state    <= ST_IDLE;
                            core_cmd <= CMD_NOP;
                            cmd_ack  <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (core_ack) begin
                        state    <= ST_IDLE;
                        core_cmd <= CMD_NOP;
                        cmd_ack  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    core_cmd <= CMD_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed testbench for i2c_master_byte_ctrl with a simple bit-controller
// model that acknowledges each command 4 cycles after it appears.
module tb_i2c_master_byte_ctrl;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, read, write, ack_in;
    logic [7:0] din;
    logic       cmd_ack, ack_out, i2c_al, core_txd;
    logic [7:0] dout;
    logic [3:0] core_cmd;
    logic       core_ack = 1'b0;
    logic       core_rxd = 1'b0;
    logic       core_al  = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [3:0] cmd_log[$];
    logic       txd_log[$];
    logic       rx_q[$];
    int         wait_cnt  = 0;
    int         al_at     = -1;
    int         ack_count = 0;

    always #5 clk = ~clk;

    i2c_master_byte_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .read     (read),
        .write    (write),
        .ack_in   (ack_in),
        .din      (din),
        .cmd_ack  (cmd_ack),
        .ack_out  (ack_out),
        .dout     (dout),
        .i2c_al   (i2c_al),
        .core_cmd (core_cmd),
        .core_txd (core_txd),
        .core_ack (core_ack),
        .core_rxd (core_rxd),
        .core_al  (core_al)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-controller model: acks each command after 4 cycles, logs it,
    // supplies core_rxd for READs and optionally raises core_al once.
    always @(negedge clk) begin
        if (rst) begin
            core_ack = 1'b0;
            core_al  = 1'b0;
            wait_cnt = 0;
        end else if (core_al) begin
            core_al = 1'b0;
        end else if (core_ack) begin
            core_ack = 1'b0;
            wait_cnt = 0;
            if (cmd_log.size() == al_at) begin
                core_al = 1'b1;
                al_at   = -1;
            end
        end else if (core_cmd != CMD_NOP) begin
            wait_cnt++;
            if (wait_cnt == 4) begin
                if (core_cmd == CMD_READ) begin
                    if (rx_q.size() > 0) core_rxd = rx_q.pop_front();
                    else                 core_rxd = 1'b0;
                end
                cmd_log.push_back(core_cmd);
                txd_log.push_back(core_txd);
                core_ack = 1'b1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (cmd_ack === 1'b1) ack_count++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic run_cmd(input logic s, input logic p, input logic r, input logic w,
                           input logic [7:0] d, input logic a);
        int n;
        cmd_log.delete();
        txd_log.delete();
        @(negedge clk);
        start = s; stop = p; read = r; write = w; din = d; ack_in = a;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cmd_ack !== 1'b1 && n < 1000);
        check("cmd_ack_seen", 32'(cmd_ack), 32'(1));
        start = 0; stop = 0; read = 0; write = 0;
        repeat (10) @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] bytev;

        rst = 1'b1; start = 0; stop = 0; read = 0; write = 0; ack_in = 0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",   32'(dut.state), 32'(ST_IDLE));
        check("rst_core_cmd", 32'(core_cmd), 32'(CMD_NOP));
        check("rst_core_txd", 32'(core_txd), 32'(0));
        check("rst_cmd_ack",  32'(cmd_ack),  32'(0));
        check("rst_ack_out",  32'(ack_out),  32'(0));
        check("rst_dout",     32'(dout),     32'(8'h00));
        @(negedge clk);
        rst = 1'b0;

        // START + WRITE 0xA5, slave ACK
        base = ack_count;
        rx_q = {1'b0};
        bytev = 8'hA5;
        run_cmd(1, 0, 0, 1, bytev, 0);
        check("t1_ncmd", 32'(cmd_log.size()), 32'(10));
        if (cmd_log.size() == 10) begin
            check("t1_start", 32'(cmd_log[0]), 32'(CMD_START));
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t1_wcmd%0d", i), 32'(cmd_log[i+1]), 32'(CMD_WRITE));
                check($sformatf("t1_txd%0d", i),  32'(txd_log[i+1]), 32'(bytev[7-i]));
            end
            check("t1_ackrd", 32'(cmd_log[9]), 32'(CMD_READ));
        end
        check("t1_ack_out", 32'(ack_out), 32'(0));
        check("t1_nack",    32'(ack_count - base), 32'(1));

        // READ with ack_in = 1 (NACK to slave)
        base = ack_count;
        rx_q = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_cmd(0, 0, 1, 0, 8'h00, 1);
        check("t2_ncmd", 32'(cmd_log.size()), 32'(9));
        if (cmd_log.size() == 9) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("t2_rcmd%0d", i), 32'(cmd_log[i]), 32'(CMD_READ));
            check("t2_ackwr",  32'(cmd_log[8]), 32'(CMD_WRITE));
            check("t2_acktxd", 32'(txd_log[8]), 32'(1));
        end
        check("t2_dout", 32'(dout), 32'(8'h3C));
        check("t2_nack", 32'(ack_count - base), 32'(1));

        // WRITE + STOP, slave NACK
        base = ack_count;
        rx_q = {1'b1};
        run_cmd(0, 1, 0, 1, 8'h5A, 0);
        check("t3_ncmd", 32'(cmd_log.size()), 32'(10));
        if (cmd_log.size() == 10) begin
            check("t3_txd0",  32'(txd_log[0]), 32'(0));
            check("t3_txd1",  32'(txd_log[1]), 32'(1));
            check("t3_ackrd", 32'(cmd_log[8]), 32'(CMD_READ));
            check("t3_stop",  32'(cmd_log[9]), 32'(CMD_STOP));
        end
        check("t3_ack_out", 32'(ack_out), 32'(1));
        check("t3_nack",    32'(ack_count - base), 32'(1));

        // Arbitration lost after the 3rd WRITE ack
        base = ack_count;
        cmd_log.delete();
        txd_log.delete();
        al_at = 4;
        @(negedge clk);
        start = 1; write = 1; din = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (core_al !== 1'b1 && n < 1000);
        check("t4_al_seen", 32'(core_al), 32'(1));
        check("t4_i2c_al",  32'(i2c_al),  32'(1));
        @(posedge clk);
        #1;
        check("t4_state",    32'(dut.state), 32'(ST_IDLE));
        check("t4_core_cmd", 32'(core_cmd),  32'(CMD_NOP));
        check("t4_cmd_ack",  32'(cmd_ack),   32'(0));
        start = 0; write = 0;
        repeat (20) @(negedge clk);
        #1;
        check("t4_nack", 32'(ack_count - base), 32'(0));
        check("t4_ncmd", 32'(cmd_log.size()), 32'(4));

        // Reset in the middle of a READ
        cmd_log.delete();
        txd_log.delete();
        rx_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        read = 1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (cmd_log.size() < 3 && n < 1000);
        check("t5_progress", 32'(cmd_log.size() >= 3), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_state",    32'(dut.state), 32'(ST_IDLE));
        check("t5_core_cmd", 32'(core_cmd),  32'(CMD_NOP));
        check("t5_core_txd", 32'(core_txd),  32'(0));
        check("t5_cmd_ack",  32'(cmd_ack),   32'(0));
        check("t5_ack_out",  32'(ack_out),   32'(0));
        check("t5_dout",     32'(dout),      32'(8'h00));
        @(negedge clk);
        rst = 1'b0;
        read = 0;
        rx_q.delete();

        // STOP-only command after reset
        base = ack_count;
        run_cmd(0, 1, 0, 0, 8'h00, 0);
        check("t5s_ncmd", 32'(cmd_log.size()), 32'(1));
        check("t5s_stop", 32'(cmd_log[0]), 32'(CMD_STOP));
        check("t5s_nack", 32'(ack_count - base), 32'(1));

        // WRITE without stop, slave NACK
        base = ack_count;
        rx_q = {1'b1};
        run_cmd(0, 0, 0, 1, 8'h00, 0);
`ifdef I2C_AUTO_STOP_ON_NACK_EN
        check("t6_ncmd", 32'(cmd_log.size()), 32'(10));
        if (cmd_log.size() == 10)
            check("t6_stop", 32'(cmd_log[9]), 32'(CMD_STOP));
`else
        check("t6_ncmd", 32'(cmd_log.size()), 32'(9));
        if (cmd_log.size() == 9)
            check("t6_ackrd", 32'(cmd_log[8]), 32'(CMD_READ));
`endif
        check("t6_ack_out", 32'(ack_out), 32'(1));
        check("t6_nack",    32'(ack_count - base), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
